// File: rtl/mem_request_scheduler.sv
// mem_request_scheduler
// Shares one memory port between VGA, audio and CPU requesters on the
// SDRAM clock domain. It uses fixed priority VGA > audio > CPU. A CPU that
// has waited too long is promoted to the top. The owner keeps the port for
// its whole burst. A watchdog aborts a transaction whose back end stops
// acknowledging.
//
// Handshake: a requester holds *_cs high until it sees the port granted
// (owner shows its code). The back end raises mem_ack for exactly one cycle
// per word while mem_cs is high. That same cycle the owner's *_ack is high
// combinationally and *_dout carries the word. After the last word,
// mem_cs is low for at least two cycles before the next grant.
module mem_request_scheduler #(
    parameter int         STARVE_LIMIT = 64,
    parameter int         TIMEOUT      = 1024,
    parameter logic [1:0] AUDIO_ACC    = 2'b10
) (
    input  logic        clk,
    input  logic        res_n,

    input  logic [31:0] vga_addr,
    input  logic        vga_cs,
    input  logic [1:0]  vga_acc,
    input  logic [8:0]  vga_burst,
    output logic [31:0] vga_dout,
    output logic        vga_ack,

    input  logic [31:0] audio_addr,
    input  logic        audio_cs,
    output logic [31:0] audio_dout,
    output logic        audio_ack,

    input  logic [31:0] cpu_addr,
    input  logic        cpu_cs,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_acc,
    input  logic [8:0]  cpu_burst,
    input  logic [31:0] cpu_din,
    input  logic        cpu_lsb_mask_en,
    output logic [31:0] cpu_dout,
    output logic        cpu_ack,

    output logic [31:0] mem_addr,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic [1:0]  mem_acc,
    output logic [8:0]  mem_burst,
    output logic [31:0] mem_din,
    output logic        mem_lsb_mask_en,
    input  logic [31:0] mem_dout,
    input  logic        mem_ack,

    output logic [1:0]  owner,
    output logic        timeout_err,
    input  logic        err_clr,

    output logic [1:0]  state_dbg
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;
    localparam int WDOG_W   = $clog2(TIMEOUT) + 1;

    localparam logic [STARVE_W-1:0] STARVE_THRESH = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX    = {STARVE_W{1'b1}};
    localparam logic [WDOG_W-1:0]   WDOG_LAST     = WDOG_W'(TIMEOUT - 1);

    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_VGA   = 2'b01;
    localparam logic [1:0] OWN_AUDIO = 2'b10;
    localparam logic [1:0] OWN_CPU   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                state;
    logic [8:0]            remaining;
    logic [WDOG_W-1:0]     wdog;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  abort_pulse;
    logic [1:0]            sel_owner;
    logic                  cpu_starved;
    logic                  abort_now;
    logic                  ack_live;

    // A burst field of zero still moves one word.
    function automatic logic [8:0] burst_words(input logic [8:0] b);
        return (b == 9'd0) ? 9'd1 : b;
    endfunction

    assign cpu_starved = cpu_cs && (starve_cnt >= STARVE_THRESH);

    // Pick the requester that would win if the port were free this cycle.
    always_comb begin
        sel_owner = OWN_NONE;
        if (cpu_starved) begin
            sel_owner = OWN_CPU;
        end else if (vga_cs) begin
            sel_owner = OWN_VGA;
        end else if (audio_cs) begin
            sel_owner = OWN_AUDIO;
        end else if (cpu_cs) begin
            sel_owner = OWN_CPU;
        end
    end

    // The watchdog fires on the last silent cycle, not on a cycle that acks.
    assign abort_now = (state == ST_BUSY) && !mem_ack && (wdog == WDOG_LAST);

    // Acks pass through with zero latency while busy. An abort produces one
    // synthetic ack during the release cycle, while owner is still valid.
    assign ack_live  = ((state == ST_BUSY) && mem_ack) || abort_pulse;
    assign vga_ack   = ack_live && (owner == OWN_VGA);
    assign audio_ack = ack_live && (owner == OWN_AUDIO);
    assign cpu_ack   = ack_live && (owner == OWN_CPU);

    assign vga_dout   = abort_pulse ? 32'd0 : mem_dout;
    assign audio_dout = abort_pulse ? 32'd0 : mem_dout;
    assign cpu_dout   = abort_pulse ? 32'd0 : mem_dout;

    // Write data stays live so the CPU can present a new word after each ack.
    assign mem_din = (owner == OWN_CPU) ? cpu_din : 32'd0;

    assign state_dbg = state;

    // Main sequencer: grant, burst ownership, watchdog abort and release gap.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state           <= ST_IDLE;
            owner           <= OWN_NONE;
            mem_addr        <= 32'd0;
            mem_cs          <= 1'b0;
            mem_wr          <= 1'b0;
            mem_acc         <= 2'b00;
            mem_burst       <= 9'd0;
            mem_lsb_mask_en <= 1'b0;
            remaining       <= 9'd0;
            wdog            <= '0;
            abort_pulse     <= 1'b0;
        end else begin
            abort_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_owner != OWN_NONE) begin
                        owner  <= sel_owner;
                        mem_cs <= 1'b1;
                        wdog   <= '0;
                        state  <= ST_BUSY;
                        case (sel_owner)
                            OWN_VGA: begin
                                mem_addr        <= vga_addr;
                                mem_wr          <= 1'b0;
                                mem_acc         <= vga_acc;
                                mem_burst       <= vga_burst;
                                mem_lsb_mask_en <= 1'b0;
                                remaining       <= burst_words(vga_burst);
                            end
                            OWN_AUDIO: begin
                                mem_addr        <= audio_addr;
                                mem_wr          <= 1'b0;
                                mem_acc         <= AUDIO_ACC;
                                mem_burst       <= 9'd1;
                                mem_lsb_mask_en <= 1'b0;
                                remaining       <= 9'd1;
                            end
                            OWN_CPU: begin
                                mem_addr        <= cpu_addr;
                                mem_wr          <= cpu_wr;
                                mem_acc         <= cpu_acc;
                                mem_burst       <= cpu_burst;
                                mem_lsb_mask_en <= cpu_lsb_mask_en;
                                remaining       <= burst_words(cpu_burst);
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        wdog <= '0;
                        if (remaining == 9'd1) begin
                            remaining <= 9'd0;
                            mem_cs    <= 1'b0;
                            state     <= ST_RELEASE;
                        end else begin
                            remaining <= remaining - 9'd1;
                        end
                    end else if (abort_now) begin
                        mem_cs      <= 1'b0;
                        abort_pulse <= 1'b1;
                        wdog        <= '0;
                        state       <= ST_RELEASE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Requests are not looked at here, so a stale cs is not re-granted.
                    owner <= OWN_NONE;
                    state <= ST_IDLE;
                end
                default: begin
                    owner  <= OWN_NONE;
                    mem_cs <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // CPU aging: counts cycles the CPU waits while the port belongs to someone else.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if ((sel_owner == OWN_CPU) || !cpu_cs) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else if (cpu_cs && (owner != OWN_CPU) && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Sticky abort flag. A new abort takes precedence over a clear in the same cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            timeout_err <= 1'b0;
        end else if (abort_now) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_request_scheduler.sv
module tb_mem_request_scheduler;
  localparam int STARVE_LIMIT = 8;
  localparam int TIMEOUT      = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] vga_addr = '0, audio_addr = '0, cpu_addr = '0, cpu_din = '0, mem_dout = '0;
  logic        vga_cs = 0, audio_cs = 0, cpu_cs = 0, cpu_wr = 0, cpu_lsb_mask_en = 0;
  logic [1:0]  vga_acc = '0, cpu_acc = '0;
  logic [8:0]  vga_burst = '0, cpu_burst = '0;
  logic        mem_ack = 0, err_clr = 0;
  logic [31:0] vga_dout, audio_dout, cpu_dout, mem_addr, mem_din;
  logic        vga_ack, audio_ack, cpu_ack, mem_cs, mem_wr, mem_lsb_mask_en, timeout_err;
  logic [1:0]  mem_acc, owner, state_dbg;
  logic [8:0]  mem_burst;

  mem_request_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT), .AUDIO_ACC(2'b10)) dut (
    .clk(clk), .res_n(res_n),
    .vga_addr(vga_addr), .vga_cs(vga_cs), .vga_acc(vga_acc), .vga_burst(vga_burst),
    .vga_dout(vga_dout), .vga_ack(vga_ack),
    .audio_addr(audio_addr), .audio_cs(audio_cs), .audio_dout(audio_dout), .audio_ack(audio_ack),
    .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_acc(cpu_acc), .cpu_burst(cpu_burst),
    .cpu_din(cpu_din), .cpu_lsb_mask_en(cpu_lsb_mask_en), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_acc(mem_acc), .mem_burst(mem_burst),
    .mem_din(mem_din), .mem_lsb_mask_en(mem_lsb_mask_en), .mem_dout(mem_dout), .mem_ack(mem_ack),
    .owner(owner), .timeout_err(timeout_err), .err_clr(err_clr), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  int vga_ack_cnt = 0, audio_ack_cnt = 0, cpu_ack_cnt = 0;
  logic [31:0] last_dout = '0;
  logic [1:0]  grant_q[$];
  int          gap_q[$];
  logic [1:0]  exp_q[$];
  int          low_cnt = 0;
  logic        mem_cs_q = 1'b0;

  // Monitor on the falling edge: ack counts, grant order, low gaps.
  always @(negedge clk) begin
    if (vga_ack) begin vga_ack_cnt++; last_dout = vga_dout; end
    if (audio_ack) begin audio_ack_cnt++; last_dout = audio_dout; end
    if (cpu_ack) begin cpu_ack_cnt++; last_dout = cpu_dout; end
    if (mem_cs && !mem_cs_q) begin
      grant_q.push_back(owner);
      gap_q.push_back(low_cnt);
      low_cnt = 0;
    end else if (!mem_cs) begin
      low_cnt++;
    end
    mem_cs_q = mem_cs;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    vga_ack_cnt = 0; audio_ack_cnt = 0; cpu_ack_cnt = 0;
    grant_q.delete(); gap_q.delete(); exp_q.delete(); low_cnt = 0;
  endtask

  task automatic wait_grant(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_cs) begin ok = 1'b1; break; end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic ack_words(input int n, input int delay, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      repeat (delay) tick();
      mem_dout = base + 32'(i);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic set_cs(input logic [1:0] who, input logic v);
    case (who)
      2'b01: vga_cs = v;
      2'b10: audio_cs = v;
      2'b11: cpu_cs = v;
      default: ;
    endcase
  endtask

  function automatic int ack_cnt_of(input logic [1:0] who);
    case (who)
      2'b01: return vga_ack_cnt;
      2'b10: return audio_ack_cnt;
      2'b11: return cpu_ack_cnt;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  who;
    logic [31:0] addr;
    logic [8:0]  burst;
    logic        wr;
    logic [1:0]  acc;
    logic        lsb;
    logic [31:0] din;
    logic [8:0]  exp_burst;
    logic [1:0]  exp_acc;
    logic        exp_wr;
    logic        exp_lsb;
    int          exp_acks;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] din_tbl[4];

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] base;
    int hi;
    vecs[0] = '{2'b10, 32'h0000_0100, 9'd0, 1'b0, 2'b00, 1'b0, 32'h0,          9'd1, 2'b10, 1'b0, 1'b0, 1};
    vecs[1] = '{2'b01, 32'h0000_2000, 9'd3, 1'b0, 2'b01, 1'b0, 32'h0,          9'd3, 2'b01, 1'b0, 1'b0, 3};
    vecs[2] = '{2'b11, 32'h0000_3000, 9'd2, 1'b0, 2'b11, 1'b1, 32'h1111_2222,  9'd2, 2'b11, 1'b0, 1'b1, 2};
    vecs[3] = '{2'b11, 32'h0000_3400, 9'd0, 1'b1, 2'b00, 1'b0, 32'h3333_4444,  9'd0, 2'b00, 1'b1, 1'b0, 1};
    vecs[4] = '{2'b01, 32'h0000_5000, 9'd0, 1'b0, 2'b10, 1'b0, 32'h0,          9'd0, 2'b10, 1'b0, 1'b0, 1};
    vecs[5] = '{2'b10, 32'hDEAD_BEEC, 9'd0, 1'b0, 2'b00, 1'b0, 32'h0,          9'd1, 2'b10, 1'b0, 1'b0, 1};
    din_tbl[0] = 32'hA5A5_0001; din_tbl[1] = 32'h5A5A_0002;
    din_tbl[2] = 32'h1234_5678; din_tbl[3] = 32'hCAFE_F00D;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst mem_cs", 32'(mem_cs), 32'd0);
    check("rst owner", 32'(owner), 32'd0);
    check("rst acks", 32'({vga_ack, audio_ack, cpu_ack}), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_din", mem_din, 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    check("rst state", 32'(state_dbg), 32'd0);
    tick();
    res_n = 1'b1;
    tick();

    // Stray mem_ack in IDLE
    mem_ack = 1'b1;
    @(negedge clk);
    check("idle ack ignored", 32'({vga_ack, audio_ack, cpu_ack}), 32'd0);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    check("idle stays idle", 32'(mem_cs), 32'd0);

    // Audio grant latency: cs seen at edge k, mem_cs high only after k
    tick();
    clear_mon();
    audio_addr = 32'h100;
    audio_cs = 1'b1;
    @(negedge clk);
    check("audio cs before edge", 32'(mem_cs), 32'd0);
    @(negedge clk);
    check("audio cs after edge", 32'(mem_cs), 32'd1);
    audio_cs = 1'b0;
    ack_words(1, 3, 32'h0BAD_F00D);
    tick(); tick();
    check("audio one ack", 32'(audio_ack_cnt), 32'd1);
    check("audio dout", last_dout, 32'h0BAD_F00D);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      tick();
      clear_mon();
      case (vecs[i].who)
        2'b01: begin vga_addr = vecs[i].addr; vga_burst = vecs[i].burst; vga_acc = vecs[i].acc; end
        2'b10: audio_addr = vecs[i].addr;
        default: begin
          cpu_addr = vecs[i].addr; cpu_burst = vecs[i].burst; cpu_acc = vecs[i].acc;
          cpu_wr = vecs[i].wr; cpu_lsb_mask_en = vecs[i].lsb; cpu_din = vecs[i].din;
        end
      endcase
      set_cs(vecs[i].who, 1'b1);
      wait_grant($sformatf("v%0d grant", i));
      check($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].who));
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("v%0d mem_burst", i), 32'(mem_burst), 32'(vecs[i].exp_burst));
      check($sformatf("v%0d mem_acc", i), 32'(mem_acc), 32'(vecs[i].exp_acc));
      check($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d mem_lsb", i), 32'(mem_lsb_mask_en), 32'(vecs[i].exp_lsb));
      check($sformatf("v%0d mem_din", i), mem_din, (vecs[i].who == 2'b11) ? vecs[i].din : 32'd0);
      set_cs(vecs[i].who, 1'b0);
      base = 32'(32'h1000 * (i + 1));
      ack_words(vecs[i].exp_acks, 1, base);
      @(negedge clk);
      check($sformatf("v%0d cs low after last", i), 32'(mem_cs), 32'd0);
      check($sformatf("v%0d release state", i), 32'(state_dbg), 32'd2);
      tick();
      check($sformatf("v%0d ack count", i), 32'(ack_cnt_of(vecs[i].who)), 32'(vecs[i].exp_acks));
      check($sformatf("v%0d last dout", i), last_dout, base + 32'(vecs[i].exp_acks - 1));
      @(negedge clk);
      check($sformatf("v%0d owner idle", i), 32'(owner), 32'd0);
    end

    // Simultaneous requests: order VGA, audio, CPU with two-cycle gaps
    tick();
    clear_mon();
    exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    vga_burst = 9'd2; cpu_burst = 9'd2; cpu_wr = 1'b0;
    vga_cs = 1'b1; audio_cs = 1'b1; cpu_cs = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_grant($sformatf("prio grant %0d", g));
      set_cs(owner, 1'b0);
      ack_words((owner == 2'b10) ? 1 : 2, 1, 32'h2000);
    end
    vga_cs = 1'b0; audio_cs = 1'b0; cpu_cs = 1'b0;
    repeat (3) tick();
    check("prio grants", 32'(grant_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < grant_q.size()) check($sformatf("prio order %0d", k), 32'(grant_q[k]), 32'(exp_q[k]));
    if (gap_q.size() == 3) begin
      check("prio gap 1", 32'(gap_q[1]), 32'd2);
      check("prio gap 2", 32'(gap_q[2]), 32'd2);
    end else begin
      check("prio gap count", 32'(gap_q.size()), 32'd3);
    end

    // Starvation: VGA re-requests forever, CPU promoted on the third IDLE
    tick();
    clear_mon();
    exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b11); exp_q.push_back(2'b01);
    vga_burst = 9'd1; cpu_burst = 9'd1; cpu_wr = 1'b0;
    vga_cs = 1'b1; cpu_cs = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_grant($sformatf("starve grant %0d", g));
      if (owner == 2'b11) cpu_cs = 1'b0;
      ack_words(1, 1, 32'h3000);
    end
    vga_cs = 1'b0; cpu_cs = 1'b0;
    repeat (3) tick();
    check("starve grants", 32'(grant_q.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < grant_q.size()) check($sformatf("starve order %0d", k), 32'(grant_q[k]), 32'(exp_q[k]));

    // CPU write burst of 4 with per-word data
    tick();
    clear_mon();
    cpu_addr = 32'h6000; cpu_burst = 9'd4; cpu_wr = 1'b1; cpu_din = din_tbl[0];
    cpu_cs = 1'b1;
    wait_grant("wr grant");
    check("wr mem_wr", 32'(mem_wr), 32'd1);
    check("wr first din", mem_din, din_tbl[0]);
    cpu_cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cpu_din = din_tbl[i];
      mem_ack = 1'b1;
      @(negedge clk);
      check($sformatf("wr din %0d", i), mem_din, din_tbl[i]);
      check($sformatf("wr ack %0d", i), 32'(cpu_ack), 32'd1);
      check($sformatf("wr mem_wr %0d", i), 32'(mem_wr), 32'd1);
      tick();
      mem_ack = 1'b0;
    end
    @(negedge clk);
    check("wr cs low", 32'(mem_cs), 32'd0);
    check("wr release", 32'(state_dbg), 32'd2);
    tick();
    check("wr ack count", 32'(cpu_ack_cnt), 32'd4);

    // Watchdog: VGA never acked
    repeat (2) tick();
    clear_mon();
    vga_addr = 32'h7000; vga_burst = 9'd4; mem_dout = 32'hFFFF_FFFF;
    vga_cs = 1'b1;
    wait_grant("to grant");
    vga_cs = 1'b0;
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_cs) hi++;
      else break;
    end
    check("to busy cycles", 32'(hi), 32'(TIMEOUT));
    check("to vga_ack", 32'(vga_ack), 32'd1);
    check("to vga_dout", vga_dout, 32'd0);
    check("to err set", 32'(timeout_err), 32'd1);
    tick();
    @(negedge clk);
    check("to ack single", 32'(vga_ack), 32'd0);
    repeat (3) tick();
    check("to err sticky", 32'(timeout_err), 32'd1);
    check("to ack count", 32'(vga_ack_cnt), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("to err cleared", 32'(timeout_err), 32'd0);

    // Abort and clear together: set wins
    tick();
    clear_mon();
    err_clr = 1'b1;
    audio_addr = 32'h7100;
    audio_cs = 1'b1;
    wait_grant("to2 grant");
    audio_cs = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_cs) break;
    end
    check("to2 audio_ack", 32'(audio_ack), 32'd1);
    check("to2 audio_dout", audio_dout, 32'd0);
    check("to2 set wins", 32'(timeout_err), 32'd1);
    err_clr = 1'b0;
    tick();
    @(negedge clk);
    check("to2 err held", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("to2 err cleared", 32'(timeout_err), 32'd0);

    // Reset mid-burst, then a full fresh burst of 8
    tick();
    clear_mon();
    cpu_addr = 32'h8000; cpu_burst = 9'd8; cpu_wr = 1'b0; cpu_acc = 2'b01;
    cpu_cs = 1'b1;
    wait_grant("rb grant");
    cpu_cs = 1'b0;
    ack_words(3, 1, 32'h8800);
    mem_ack = 1'b1;
    #2;
    res_n = 1'b0;
    #1;
    check("rb mem_cs", 32'(mem_cs), 32'd0);
    check("rb owner", 32'(owner), 32'd0);
    check("rb cpu_ack", 32'(cpu_ack), 32'd0);
    check("rb mem_burst", 32'(mem_burst), 32'd0);
    check("rb mem_addr", mem_addr, 32'd0);
    mem_ack = 1'b0;
    tick(); tick();
    res_n = 1'b1;
    tick();
    clear_mon();
    cpu_addr = 32'h9000; cpu_cs = 1'b1;
    wait_grant("rb2 grant");
    check("rb2 owner", 32'(owner), 32'd3);
    check("rb2 mem_burst", 32'(mem_burst), 32'd8);
    cpu_cs = 1'b0;
    ack_words(7, 1, 32'h9900);
    @(negedge clk);
    check("rb2 busy after 7", 32'(mem_cs), 32'd1);
    ack_words(1, 1, 32'h9907);
    @(negedge clk);
    check("rb2 cs low after 8", 32'(mem_cs), 32'd0);
    tick();
    check("rb2 ack count", 32'(cpu_ack_cnt), 32'd8);
    check("rb2 last dout", last_dout, 32'h9907);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
